// File: rtl/mips_pkg.sv
// Shared encodings and sizes for the MIPS datapath memory blocks.
package mips_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_BU = 3'b001;
  localparam logic [2:0] DM_B  = 3'b010;
  localparam logic [2:0] DM_HU = 3'b011;
  localparam logic [2:0] DM_H  = 3'b100;

  localparam int DM_DEPTH = 3072;

  // Reserved codes 101-111 fall through to word access.
  function automatic logic dm_is_byte(input logic [2:0] op);
    return (op == DM_BU) || (op == DM_B);
  endfunction

  function automatic logic dm_is_half(input logic [2:0] op);
    return (op == DM_HU) || (op == DM_H);
  endfunction

  function automatic logic dm_is_word(input logic [2:0] op);
    return !dm_is_byte(op) && !dm_is_half(op);
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Lane selector and zero/sign extender for load data; shared with the device bridge.
module dm_ext
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  DMOp,
  output logic [31:0] RD
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    byte_s = word[7:0];
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend according to the access type.
  always_comb begin
    RD = word;
    case (DMOp)
      DM_BU:   RD = {24'd0, byte_s};
      DM_B:    RD = {{24{byte_s[7]}}, byte_s};
      DM_HU:   RD = {16'd0, half_s};
      DM_H:    RD = {{16{half_s[15]}}, half_s};
      default: RD = word;
    endcase
  end

endmodule

// File: rtl/dm_word_lane.sv
// Byte-addressable data memory: read-modify-write stores on the clock edge,
// combinational extended loads, and address error flags.
module dm_word_lane
  import mips_pkg::*;
#(
  parameter int DEPTH  = DM_DEPTH,
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [2:0]  DMOp,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        ExcAdEL,
  output logic        ExcAdES
);

  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] idx_s;
  logic [1:0]        lane_s;
  logic              misaligned_s;
  logic              out_of_range_s;
  logic              fault_s;
  logic              store_en_s;
  logic [31:0]       old_word_s;
  logic [31:0]       merged_s;
  logic [31:0]       ext_rd_s;

  assign lane_s         = Addr[1:0];
  assign out_of_range_s = (Addr >= BYTE_LIMIT);
  // Force index 0 when out of range so the array is never read past its end.
  assign idx_s          = out_of_range_s ? {ADDR_W{1'b0}} : Addr[ADDR_W+1:2];
  assign misaligned_s   = (dm_is_word(DMOp) && (lane_s != 2'b00)) ||
                          (dm_is_half(DMOp) && lane_s[0]);
  assign fault_s        = misaligned_s || out_of_range_s;
  assign ExcAdES        = WE && fault_s;
  assign ExcAdEL        = !WE && fault_s;
  assign store_en_s     = WE && !ExcAdES && !reset;
  assign old_word_s     = mem_r[idx_s];

  // Merge store data into the current word; untouched lanes keep their contents.
  always_comb begin
    merged_s = old_word_s;
    case (DMOp)
      DM_BU, DM_B: begin
        case (lane_s)
          2'd0:    merged_s[7:0]   = WD[7:0];
          2'd1:    merged_s[15:8]  = WD[7:0];
          2'd2:    merged_s[23:16] = WD[7:0];
          2'd3:    merged_s[31:24] = WD[7:0];
          default: merged_s        = old_word_s;
        endcase
      end
      DM_HU, DM_H: begin
        if (lane_s[1]) begin
          merged_s[31:16] = WD[15:0];
        end else begin
          merged_s[15:0] = WD[15:0];
        end
      end
      default: merged_s = WD;
    endcase
  end

  // Storage: reset clears every word and wins over a simultaneous store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (store_en_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

`ifndef SYNTHESIS
  // Write log of each accepted store, showing the merged word.
  always_ff @(posedge clk) begin
    if (store_en_s) begin
      $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, merged_s);
    end
  end
`endif

  dm_ext u_ext (
    .word (old_word_s),
    .lane (lane_s),
    .DMOp (DMOp),
    .RD   (ext_rd_s)
  );

  assign RD = out_of_range_s ? 32'd0 : ext_rd_s;

endmodule

// File: doc/dm_word_lane.md
# dm_word_lane

Byte-addressable data memory for the single-cycle MIPS datapath. It sits directly downstream of the ALU: the ALU result `C` drives `Addr`, and the register-file read port 2 drives `WD`. It performs word, halfword and byte stores as read-modify-write of one 32-bit word on the clock edge. It returns zero- or sign-extended load data combinationally and flags misaligned or out-of-range accesses.

## Interface
Parameters:
- `DEPTH`, 3072: number of 32-bit words. The valid byte range is 0 to `DEPTH*4-1` (0x0000–0x2FFF).
- `ADDR_W`, 12: word-index width, equal to ceil(log2 `DEPTH`).

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears every word on the next rising edge.
- `WE`  in  1  store enable from the control unit.
- `Addr`  in  32  byte address, taken from ALU output `C`.
- `WD`  in  32  store data; the low byte or halfword is used for sb/sh.
- `DMOp`  in  3  access type: 000 word; 001 byte unsigned; 010 byte signed; 011 half unsigned; 100 half signed. 101–111 are reserved and treated as word.
- `PC`  in  32  PC of the current instruction, used only for the write log.
- `RD`  out  32  extended load data.
- `ExcAdEL`  out  1  load address error.
- `ExcAdES`  out  1  store address error.

## Operation
- Word index is `Addr[ADDR_W+1:2]`; lane is `Addr[1:0]`.
- Misaligned access:
  - word access with `Addr[1:0]!=0`;
  - half access with `Addr[0]!=0`.
- Out of range: `Addr >= DEPTH*4`, compared unsigned on the full 32 bits.
- Error flags:
  - `ExcAdES = WE & (misaligned | out_of_range)`.
  - `ExcAdEL = !WE & (misaligned | out_of_range)`.
  - The current datapath issues a load whenever `WE=0`, so `ExcAdEL` is informational only.
- Load, combinational:
  - Select the byte `Addr[1:0]` or the half `Addr[1]` from `mem[index]`.
  - Zero-extend for 001/011; sign-extend for 010/100.
  - `RD=0` whenever the address is out of range.
- Store, on the rising edge when `WE & !ExcAdES & !reset`:
  - Word: replaces the whole word.
  - Half: replaces bits [15:0] or [31:16] with `WD[15:0]`.
  - Byte: replaces lane `Addr[1:0]` with `WD[7:0]`.
  - Other lanes keep their contents.
- Write log, simulation only, once per accepted store: `$display("@%h: *%h <= %h", PC, {Addr[31:2],2'b00}, merged_word)`. It prints the full merged word, not the raw `WD`.
- A faulting store does not change memory and does not print.

## Timing
- Reset:
  - All `DEPTH` words become 0 on the first rising edge with `reset=1`.
  - `RD` reads 0 from the next cycle.
  - Reset overrides a simultaneous store, even mid-program.
- Load latency is 0 cycles; `RD` follows `Addr`/`DMOp`/memory combinationally.
- Store latency is 1 edge: the new value is visible on `RD` in the cycle after the edge.
- A store and a read of the same word in the same cycle: `RD` returns the old value.
- Back-to-back stores to different lanes of the same word accumulate, since each merge reads the post-previous-edge contents.
- Outputs after reset: `RD=0` for any in-range address; `ExcAdEL`/`ExcAdES` are purely combinational on the inputs.

## Structure
- Package `mips_pkg`:
  - `DMOp` encodings as localparams (`DM_W`, `DM_BU`, `DM_B`, `DM_HU`, `DM_H`);
  - `DM_DEPTH=3072`.
- Sub-module `dm_ext`: a pure combinational lane selector and extender (`word`, `lane[1:0]`, `DMOp` to `RD`). It is reused later when a bridge adds memory-mapped devices.
- Top: storage array, merge logic, error checks and write log.

## Test plan
- Reset then read: assert `reset` for 1 cycle, then load word at 0x0000 and 0x2FFC → `RD=0`, no flags.
- Word store/load:
  - Store word `WD=0x12345678` at 0x0004 with `PC=0x3000` → log `@00003000: *00000004 <= 12345678`.
  - Next cycle, load word → `RD=0x12345678`.
- Byte merge and extension:
  - On a word holding 0x12345678, sb `WD=0x000000AB` at 0x0006 → word 0x12AB5678.
  - Load byte signed at 0x0006 → 0xFFFFFFAB.
  - Load byte unsigned at 0x0006 → 0x000000AB.
- Half store/load:
  - sh `WD=0x8001` at 0x000A → upper half 0x8001.
  - Load half signed at 0x000A → 0xFFFF8001.
  - Load half unsigned at 0x000A → 0x00008001.
- Faults:
  - sw at 0x0002 → `ExcAdES=1`, memory unchanged, no log.
  - Load word at 0x3000 → `ExcAdEL=1`, `RD=0`.
  - Half load at 0x0001 → `ExcAdEL=1`.
- Reset with simultaneous store: `reset=1` and `WE=1` with `WD=0xFFFFFFFF` at 0x0004 → next cycle `RD=0` at 0x0004, no log.
